// File: rtl/dbg_frame_streamer.sv
// ---------------------------------------------------------------------------
// dbg_frame_streamer
//
// Purpose:
//   Captures a snapshot of NUM_BYTES debug bytes on a qualified trigger edge
//   and streams it to a byte-wide UART as a framed packet:
//     [SYNC_BYTE] seq data[NUM_BYTES-1] .. data[0] [checksum]
//   The checksum is the mod-256 sum of the seq byte and all data bytes.
//   Triggers that arrive while a frame is in flight are counted in 'dropped'.
//
// Ports:
//   clk             device clock, rising edge
//   rst_n           asynchronous active-low reset
//   trig_in         trigger level, asynchronous to clk
//   qual            trigger qualifier (used in mode 2'b10)
//   mode            00 off, 01 every edge, 10 edge AND qual, 11 single-shot
//   snap_data       flat debug vector, byte NUM_BYTES-1 at the MSBs
//   is_transmitting UART busy flag
//   transmit        one-cycle send request to the UART
//   tx_byte         byte to send, valid while transmit=1, held otherwise
//   busy            a frame is in flight
//   seq             sequence number of the next frame
//   dropped         saturating count of accepted triggers lost to overrun
// ---------------------------------------------------------------------------
module dbg_frame_streamer #(
    parameter int         NUM_BYTES = 14,
    parameter int         SYNC_EN   = 1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CSUM_EN   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trig_in,
    input  logic                   qual,
    input  logic [1:0]             mode,
    input  logic [NUM_BYTES*8-1:0] snap_data,
    input  logic                   is_transmitting,
    output logic                   transmit,
    output logic [7:0]             tx_byte,
    output logic                   busy,
    output logic [7:0]             seq,
    output logic [7:0]             dropped
);

    localparam int FRAME_LEN = NUM_BYTES + 1 + SYNC_EN + CSUM_EN;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int SEQ_POS   = SYNC_EN;
    localparam int DATA_POS  = SYNC_EN + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic                   trig_s1;
    logic                   trig_s2;
    logic                   trig_s3;
    logic                   trig_edge;
    logic                   shot_flag;
    logic                   accept;
    logic [1:0]             state;
    logic [IDX_W-1:0]       byte_idx;
    logic [NUM_BYTES*8-1:0] snap_reg;
    logic [7:0]             seq_lat;
    logic [7:0]             tx_hold;
    logic [7:0]             csum;
    logic [7:0]             cur_byte;

    // Two flops resynchronise trig_in; the third only serves edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trig_in;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    assign trig_edge = trig_s2 & ~trig_s3;

    always_comb begin
        accept = 1'b0;
        if (trig_edge) begin
            case (mode)
                2'b01:   accept = 1'b1;
                2'b10:   accept = qual;
                2'b11:   accept = ~shot_flag;
                default: accept = 1'b0;
            endcase
        end
    end

    // Single-shot arm: leaving mode 11 re-arms for the next time it is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shot_flag <= 1'b0;
        end else if (mode != 2'b11) begin
            shot_flag <= 1'b0;
        end else if (accept) begin
            shot_flag <= 1'b1;
        end
    end

    always_comb begin
        csum = seq_lat;
        for (int i = 0; i < NUM_BYTES; i++) begin
            csum = csum + snap_reg[i*8 +: 8];
        end
    end

    // Frame position -> byte. The checksum is the fallback because it is the
    // only position not matched below (and unreachable when CSUM_EN=0).
    always_comb begin
        cur_byte = csum;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_idx == IDX_W'(DATA_POS + i)) begin
                cur_byte = snap_reg[(NUM_BYTES-1-i)*8 +: 8];
            end
        end
        if (byte_idx == IDX_W'(SEQ_POS)) begin
            cur_byte = seq_lat;
        end
        if (SYNC_EN != 0 && byte_idx == '0) begin
            cur_byte = SYNC_BYTE;
        end
    end

    // transmit is decoded from state so a reset drops it without waiting a clock.
    assign transmit = (state == ST_SEND);
    assign tx_byte  = transmit ? cur_byte : tx_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            byte_idx <= '0;
            snap_reg <= '0;
            seq_lat  <= 8'h00;
            tx_hold  <= 8'h00;
            busy     <= 1'b0;
            seq      <= 8'h00;
            dropped  <= 8'h00;
        end else begin
            if (accept && state != ST_IDLE && dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        snap_reg <= snap_data;
                        seq_lat  <= seq;
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_hold <= cur_byte;
                    state   <= ST_GUARD;
                end
                // The UART raises its busy flag a cycle after the request, so
                // is_transmitting is not trusted here.
                ST_GUARD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!is_transmitting) begin
                        if (byte_idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            seq   <= seq + 8'd1;
                            state <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                            state    <= ST_SEND;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
